// File: rtl/qk_inst_sequencer.sv
// Instruction sequencer for mac_array_top: streams Q/K rows into qmem/kmem, loads K,
// executes, then drains ofifo rows to a downstream consumer.
module qk_inst_sequencer #(
  parameter int unsigned col      = 8,
  parameter int unsigned pr       = 8,
  parameter int unsigned bw       = 8,
  parameter int unsigned bw_psum  = 19,
  parameter int unsigned LOAD_GAP = 10,
  parameter int unsigned EXEC_GAP = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              rows_m1,
  input  logic                    in_valid,
  input  logic [pr*bw-1:0]        in_data,
  output logic                    in_ready,
  output logic [18:0]             inst,
  output logic [pr*bw-1:0]        mem_in,
  input  logic [bw_psum*col-1:0]  mac_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [bw_psum*col-1:0]  out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CntW = 8;

  typedef enum logic [3:0] {
    StIdle, StQwr, StKwr, StGap, StKload, StLwait, StExec, StEwait, StRead, StDone
  } state_e;

  state_e          state_q, state_next;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      nq_m1_q;
  logic            busy_q, done_q;
  logic            step, cnt_last;

  assign mem_in   = in_data;
  assign out_data = mac_out;
  assign busy     = busy_q;
  assign done     = done_q;

  // Host/consumer handshakes gate progress only in the streaming phases.
  always_comb begin
    step       = 1'b1;
    cnt_last   = 1'b0;
    state_next = StIdle;
    case (state_q)
      StQwr: begin
        step       = in_valid;
        cnt_last   = (cnt_q == CntW'(nq_m1_q));
        state_next = StKwr;
      end
      StKwr: begin
        step       = in_valid;
        cnt_last   = (cnt_q == CntW'(col - 1));
        state_next = StGap;
      end
      StGap: begin
        cnt_last   = (cnt_q == CntW'(1));
        state_next = StKload;
      end
      StKload: begin
        cnt_last   = (cnt_q == CntW'(col + 1));
        state_next = StLwait;
      end
      StLwait: begin
        cnt_last   = (cnt_q == CntW'(LOAD_GAP - 1));
        state_next = StExec;
      end
      StExec: begin
        cnt_last   = (cnt_q == CntW'(nq_m1_q));
        state_next = StEwait;
      end
      StEwait: begin
        cnt_last   = (cnt_q == CntW'(EXEC_GAP - 1));
        state_next = StRead;
      end
      StRead: begin
        step       = out_ready;
        cnt_last   = (cnt_q == CntW'(nq_m1_q));
        state_next = StDone;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      nq_m1_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            nq_m1_q <= rows_m1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StQwr;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          if (step) begin
            if (cnt_last) begin
              cnt_q   <= '0;
              state_q <= state_next;
              done_q  <= (state_q == StRead);
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    inst      = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StQwr: begin
        in_ready = 1'b1;
        if (in_valid) begin
          inst[4]     = 1'b1;
          inst[15:12] = cnt_q[3:0];
        end
      end
      StKwr: begin
        in_ready = 1'b1;
        if (in_valid) begin
          inst[2]     = 1'b1;
          inst[15:12] = cnt_q[3:0];
        end
      end
      StKload: begin
        inst[6] = 1'b1;
        // First and last load beats carry no kmem read.
        if (cnt_q != '0 && cnt_q != CntW'(col + 1)) begin
          inst[3]     = 1'b1;
          inst[15:12] = cnt_q[3:0] - 4'd1;
        end
      end
      StExec: begin
        inst[7]     = 1'b1;
        inst[5]     = 1'b1;
        inst[15:12] = cnt_q[3:0];
      end
      StRead: begin
        out_valid = 1'b1;
        inst[16]  = out_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Bench for qk_inst_sequencer: table of runs checked cycle by cycle against a queue-based
// model of the expected instruction stream, plus reset corner sequences.
module tb_qk_inst_sequencer;

  localparam int COL = 8;
  localparam int LG  = 10;
  localparam int EG  = 10;

  localparam logic [18:0] I_RD  = 19'h10000;
  localparam logic [18:0] I_EX  = 19'h00080;
  localparam logic [18:0] I_LD  = 19'h00040;
  localparam logic [18:0] I_QRD = 19'h00020;
  localparam logic [18:0] I_QWR = 19'h00010;
  localparam logic [18:0] I_KRD = 19'h00008;
  localparam logic [18:0] I_KWR = 19'h00004;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [3:0]   rows_m1;
  logic [63:0]  in_data, mem_in;
  logic [18:0]  inst;
  logic [151:0] mac_out, out_data;

  qk_inst_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rows_m1   (rows_m1),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .inst      (inst),
    .mem_in    (mem_in),
    .mac_out   (mac_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] rows_m1;
    int         vmode;    // 0 always valid, 1 toggling, 2 random
    int         rmode;    // 0 always ready, 1 stall 3 cycles after row 2, 2 random
    bit         poke;     // random start pulses while busy
    int         reset_at; // busy-cycle index at which reset is asserted, 0 = none
    int         exp_len;  // expected busy cycles including done, 0 = unchecked
  } tcase_t;

  tcase_t tbl[11];

  // Model state: expected stream of writes, then fixed post-write stream, then reads.
  logic [18:0]  wr_q[$];
  logic [18:0]  tail_q[$];
  logic [151:0] fifo_q[$];
  logic [151:0] exp_rows[$];
  int           reads_left;
  bit           done_pend;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] at(input int a);
    return 19'(a) << 12;
  endfunction

  function automatic void build(input int nq);
    logic [151:0] row;
    wr_q = {};
    tail_q = {};
    fifo_q = {};
    exp_rows = {};
    for (int i = 0; i < nq; i++) wr_q.push_back(I_QWR | at(i));
    for (int i = 0; i < COL; i++) wr_q.push_back(I_KWR | at(i));
    repeat (2) tail_q.push_back(19'h0);
    tail_q.push_back(I_LD);
    for (int k = 1; k <= COL; k++) tail_q.push_back(I_LD | I_KRD | at(k - 1));
    tail_q.push_back(I_LD);
    repeat (LG) tail_q.push_back(19'h0);
    for (int i = 0; i < nq; i++) tail_q.push_back(I_EX | I_QRD | at(i));
    repeat (EG) tail_q.push_back(19'h0);
    for (int r = 0; r < nq; r++) begin
      row = 152'({$urandom, $urandom, $urandom, $urandom, $urandom});
      fifo_q.push_back(row);
      exp_rows.push_back(row);
    end
    reads_left = nq;
    done_pend = 1'b1;
  endfunction

  function automatic bit active();
    return (wr_q.size() != 0) || (tail_q.size() != 0) || (reads_left != 0) || done_pend;
  endfunction

  task automatic idle_check(input string name);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check(name, {inst, in_ready, out_valid, busy, done}, 23'h0);
  endtask

  task automatic run_case(input int id, input tcase_t tc);
    int          cyc = 0;
    int          xfers = 0;
    int          hold = 0;
    bit          aborted = 1'b0;
    bit          popped;
    logic [22:0] exp;
    build(int'(tc.rows_m1) + 1);
    @(negedge clk);
    start = 1'b1;
    rows_m1 = tc.rows_m1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check($sformatf("case%0d_start", id), {inst, in_ready, out_valid, busy, done}, 23'h0);
    while (active() && cyc < 400 && !aborted) begin
      @(negedge clk);
      start = tc.poke && ($urandom_range(0, 3) == 0);
      rows_m1 = 4'($urandom);
      case (tc.vmode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      case (tc.rmode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = !(xfers == 3 && hold < 3);
          if (!out_ready) hold++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_data = {$urandom, $urandom};
      mac_out = (fifo_q.size() != 0) ? fifo_q[0] : 152'h0;
      if (tc.reset_at != 0 && cyc == tc.reset_at) begin
        reset = 1'b0;
        aborted = 1'b1;
      end
      #1;
      if (wr_q.size() != 0) exp = {(in_valid ? wr_q[0] : 19'h0), 4'b1010};
      else if (tail_q.size() != 0) exp = {tail_q[0], 4'b0010};
      else if (reads_left != 0) exp = {(out_ready ? I_RD : 19'h0), 4'b0110};
      else exp = {19'h0, 4'b0011};
      check($sformatf("case%0d_cyc%0d", id, cyc), {inst, in_ready, out_valid, busy, done}, exp);
      if (wr_q.size() != 0) check($sformatf("case%0d_mem_in", id), mem_in, in_data);
      else if (tail_q.size() == 0 && reads_left != 0)
        check($sformatf("case%0d_row%0d", id, xfers), out_data, exp_rows[0]);
      popped = inst[16];
      if (wr_q.size() != 0) begin
        if (in_valid) void'(wr_q.pop_front());
      end else if (tail_q.size() != 0) begin
        void'(tail_q.pop_front());
      end else if (reads_left != 0) begin
        if (out_ready) begin
          void'(exp_rows.pop_front());
          reads_left--;
          xfers++;
        end
      end else begin
        done_pend = 1'b0;
      end
      @(posedge clk);
      if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
      cyc++;
    end
    if (aborted) begin
      wr_q = {};
      tail_q = {};
      reads_left = 0;
      done_pend = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      #1;
      check($sformatf("case%0d_after_reset", id), {inst, in_ready, out_valid, busy, done}, 23'h0);
      for (int i = 0; i < 4; i++) idle_check($sformatf("case%0d_no_done_%0d", id, i));
    end else begin
      if (active()) begin
        checks++;
        errors++;
        $display("FAIL case%0d_timeout: got no completion after %0d cycles, expected done", id, cyc);
      end
      if (tc.exp_len != 0) check($sformatf("case%0d_len", id), cyc, tc.exp_len);
      idle_check($sformatf("case%0d_idle", id));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'd7,  0, 0, 1'b0, 0,  65};
    tbl[1]  = '{4'd7,  1, 0, 1'b0, 0,  80};
    tbl[2]  = '{4'd7,  0, 1, 1'b0, 0,  68};
    tbl[3]  = '{4'd15, 0, 0, 1'b0, 0,  89};
    tbl[4]  = '{4'd0,  0, 0, 1'b0, 0,  44};
    tbl[5]  = '{4'd7,  0, 0, 1'b0, 41, 0};
    tbl[6]  = '{4'd7,  0, 0, 1'b0, 0,  65};
    for (int i = 7; i < 11; i++) tbl[i] = '{4'($urandom), 2, 2, 1'b1, 0, 0};

    reset = 1'b0;
    start = 1'b1;
    rows_m1 = 4'd7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = '0;
    mac_out = '0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("reset_hold%0d", i), {inst, in_ready, out_valid, busy, done}, 23'h0);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;

    for (int i = 0; i < 11; i++) run_case(i, tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qk_inst_sequencer.md
Name: qk_inst_sequencer

Overview:
- Hardware instruction generator that drives the 19-bit inst bus, mem_in and output capture of mac_array_top.
- Runs the full flow without a bench: Q rows into qmem, K rows into kmem, K load into the array, execute, then drain ofifo rows to a downstream consumer.
- Sits between a host stream interface and mac_array_top.

Parameters:
- col, 8, number of array columns and number of K rows loaded
- pr, 8, elements per memory word
- bw, 8, element width
- bw_psum, 19, psum width per column (2*bw+3, matching mac_array_top default)
- LOAD_GAP, 10, idle cycles between K load and execute
- EXEC_GAP, 10, idle cycles between execute and ofifo read

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- start  in  1  one-cycle request to begin a run; ignored unless IDLE
- rows_m1  in  4  Q row count minus 1 (1..16 rows); latched on accepted start
- in_valid  in  1  host word valid
- in_data  in  pr*bw  host word; Q rows first, then col K rows
- in_ready  out  1  host word accepted when in_valid&in_ready
- inst  out  19  instruction bus to mac_array_top
- mem_in  out  pr*bw  data to qmem/kmem
- mac_out  in  bw_psum*col  ofifo output from mac_array_top
- out_valid  out  1  out_data holds one result row
- out_ready  in  1  consumer accepts row
- out_data  out  bw_psum*col  equals mac_out
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run

Behaviour:
- inst map: [16] ofifo_rd, [15:12] addr, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr. Bits [18:17], [11:8] and [1:0] are always 0.
- State and counters are registered. inst, in_ready, out_valid and mem_in are combinational decodes of state plus in_valid/out_ready.
- mem_in = in_data. out_data = mac_out.
- Reset (reset==0 at an edge): state IDLE, counters 0, busy=0, done=0, inst=0, in_ready=0, out_valid=0. This applies mid-run as well: the next cycle shows all-zero inst, and there is no partial completion or done pulse.
- IDLE: start=1 latches nq=rows_m1+1, goes to QWR, and busy=1 from the next cycle.
- QWR: in_ready=1. On each accept: qmem_wr=1, addr=idx (0..nq-1), idx++. With in_valid=0: inst=0, no address advance. After nq accepts: KWR, idx=0.
- KWR: same handshake into kmem (kmem_wr, addr 0..col-1) for col accepts, then GAP. Outside QWR/KWR, in_ready=0.
- GAP: 2 cycles, inst=0.
- KLOAD: col+2 cycles, k=0..col+1, load=1 throughout. For k in 1..col: kmem_rd=1, addr=k-1. At k=0 and k=col+1: kmem_rd=0, addr=0.
- LWAIT: LOAD_GAP cycles, inst=0.
- EXEC: nq cycles with execute=1, qmem_rd=1, addr=0..nq-1.
- EWAIT: EXEC_GAP cycles, inst=0.
- READ: out_valid=1. ofifo_rd = out_ready. Each cycle with out_ready=1 is one row transfer (row r = Q row r). With out_ready=0: ofifo_rd=0 and no pop. After nq transfers: DONE.
- DONE: 1 cycle, done=1, busy=1, inst=0, then IDLE with busy=0.
- start while busy: ignored, with no effect on counters.
- nq=16: addr reaches 15 and the counter does not wrap inside a phase.
- All counter compares are exact; there are no off-by-one extra beats.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> inst=0, in_ready=0, busy=0, done=0 every cycle.
- Nominal run, rows_m1=7, in_valid always 1, out_ready always 1 -> expected inst trace:
  - 8 qmem_wr cycles at addr 0..7, then 8 kmem_wr cycles at addr 0..7
  - 2 idle cycles, then 10 load cycles with kmem_rd on cycles 1..8
  - 10 idle cycles, then 8 execute cycles at addr 0..7
  - 10 idle cycles, then 8 ofifo_rd cycles, then done pulse
  - With mac_array_top attached: out_data col c == sum_k Q[r][k]*K[7-c][k] for every row r.
- Host stalls: in_valid toggles 1,0,1,0 during QWR/KWR -> write strobes only on valid cycles, addresses stay contiguous 0..7, results unchanged.
- Backpressure: out_ready=0 for 3 cycles after READ row 2 -> ofifo_rd=0 on those cycles, rows still arrive in order 0..7, done only after the 8th transfer.
- Max rows: rows_m1=15 -> 16 Q writes and 16 execute cycles at addr 0..15, then 16 READ transfers and done.
- Mid-run reset: reset=0 during EXEC cycle 3 -> inst=0 and busy=0 on the next cycle, no done pulse; a following start repeats the nominal run with correct results.
